// File: rtl/fmap_streamer_if.sv
// Memory-read and line-buffer-feed bundle of fmap_streamer.
// master = streamer side, slave = RAM / line-buffer side.
interface fmap_streamer_if #(
  parameter int DW = 24,
  parameter int AW = 10
);
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          flush;
  logic          valid;
  logic [DW-1:0] D;

  modport master (
    output mem_en,
    output mem_addr,
    input  mem_rdata,
    output flush,
    output valid,
    output D
  );

  modport slave (
    input  mem_en,
    input  mem_addr,
    output mem_rdata,
    input  flush,
    input  valid,
    input  D
  );
endinterface

// File: rtl/fmap_streamer.sv
// Raster-scan feature-map source: RAM reads plus zero border,
// one packed pixel per cycle into the line buffer.
module fmap_streamer #(
  parameter int BITWIDTH    = 8,
  parameter int INPUT_FMAPS = 3,
  parameter int IMG_W       = 32,
  parameter int IMG_H       = 32,
  parameter int PAD         = 1,
  parameter int AW          = 10
) (
  input  logic clk,
  input  logic rstn,
  input  logic start,
  input  logic stall,
  fmap_streamer_if.master bus,
  output logic busy,
  output logic done
);

  localparam int PW = IMG_W + 2 * PAD;
  localparam int PH = IMG_H + 2 * PAD;
  localparam int CW = $clog2(PW + 8) + 1;
  localparam int RW = $clog2(PH + 8) + 1;

  localparam logic [CW-1:0] PW_M1 = CW'(PW - 1);
  localparam logic [RW-1:0] PH_M1 = RW'(PH - 1);
  localparam logic [CW-1:0] PAD_X = CW'(PAD);
  localparam logic [RW-1:0] PAD_Y = RW'(PAD);
  localparam logic [CW-1:0] W_X   = CW'(IMG_W);
  localparam logic [RW-1:0] H_Y   = RW'(IMG_H);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] px;
  logic [RW-1:0] py;
  logic [AW-1:0] addr;
  logic          valid_q;
  logic          pad_q;
  logic          flush_q;

  logic [CW-1:0] xs;
  logic [RW-1:0] ys;
  logic          interior;
  logic          issue;
  logic          row_end;
  logic          last_row;
  logic [BITWIDTH*INPUT_FMAPS-1:0] pix;

  // Offset counters wrap to huge values left/above the image,
  // so a single unsigned compare covers both border sides.
  assign xs       = px - PAD_X;
  assign ys       = py - PAD_Y;
  assign interior = (xs < W_X) && (ys < H_Y);
  assign issue    = (state == S_STREAM) && !stall;
  assign row_end  = (px == PW_M1);
  assign last_row = (py == PH_M1);

  assign pix = (valid_q && !pad_q) ? bus.mem_rdata : '0;

  assign bus.mem_en   = issue && interior;
  assign bus.mem_addr = bus.mem_en ? addr : '0;
  assign bus.flush    = flush_q;
  assign bus.valid    = valid_q;
  assign bus.D        = pix;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= S_IDLE;
      px      <= '0;
      py      <= '0;
      addr    <= '0;
      valid_q <= 1'b0;
      pad_q   <= 1'b0;
      flush_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      valid_q <= issue;
      pad_q   <= issue && !interior;
      flush_q <= 1'b0;
      done    <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_FLUSH;
            flush_q <= 1'b1;
            busy    <= 1'b1;
          end
        end
        S_FLUSH: begin
          state <= S_STREAM;
          px    <= '0;
          py    <= '0;
          addr  <= '0;
        end
        S_STREAM: begin
          if (!stall) begin
            if (interior)
              addr <= addr + 1'b1;
            if (row_end) begin
              px <= '0;
              if (last_row) begin
                py    <= '0;
                state <= S_DRAIN;
              end else begin
                py <= py + 1'b1;
              end
            end else begin
              px <= px + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fmap_streamer.sv
// Scoreboard bench for fmap_streamer: 4x3 frame, PAD=1 and PAD=0.
// RAM word a holds {3{a[7:0]}}.
module tb_fmap_streamer;

  typedef struct {
    int          kind;
    int          cyc;
    logic [23:0] d;
  } ev_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start_a = 1'b0;
  logic stall_a = 1'b0;
  logic start_b = 1'b0;
  logic stall_b = 1'b0;
  logic busy_a, done_a, busy_b, done_b;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   base_a = 0;
  int   base_b = 0;
  int   exp_a = 0;
  int   exp_b = 0;
  ev_t  qa[$];
  ev_t  qb[$];

  fmap_streamer_if #(.DW(24), .AW(10)) a_if ();
  fmap_streamer_if #(.DW(24), .AW(10)) b_if ();

  fmap_streamer #(
    .BITWIDTH(8), .INPUT_FMAPS(3), .IMG_W(4),
    .IMG_H(3), .PAD(1), .AW(10)
  ) dut_a (
    .clk(clk), .rstn(rstn), .start(start_a),
    .stall(stall_a), .bus(a_if.master),
    .busy(busy_a), .done(done_a)
  );

  fmap_streamer #(
    .BITWIDTH(8), .INPUT_FMAPS(3), .IMG_W(4),
    .IMG_H(3), .PAD(0), .AW(10)
  ) dut_b (
    .clk(clk), .rstn(rstn), .start(start_b),
    .stall(stall_b), .bus(b_if.master),
    .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (a_if.mem_en) a_if.mem_rdata <= {3{a_if.mem_addr[7:0]}};
    if (b_if.mem_en) b_if.mem_rdata <= {3{b_if.mem_addr[7:0]}};
  end

  task automatic push_ev(input bit b, input int k,
                         input int c, input logic [23:0] d);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.d    = d;
    if (b) qb.push_back(e);
    else   qa.push_back(e);
  endtask

  // Expected flush / beats / done of one 4x3 frame started in
  // cycle off; issues in [slo,shi] are stalled; issues at or
  // after cut never deliver (aborted by reset).
  task automatic push_frame(input bit b, input int off,
                            input int slo, input int shi,
                            input int cut);
    int pad, pw, ph, p, t, idx, px, py, a;
    bit in, cutoff;
    logic [7:0] ab;
    logic [23:0] d;
    pad = b ? 0 : 1;
    pw = 4 + 2 * pad;
    ph = 3 + 2 * pad;
    p = pw * ph;
    t = off + 2;
    idx = 0;
    cutoff = 0;
    push_ev(b, 0, off + 1, 24'h0);
    while (idx < p && !cutoff) begin
      if (t >= cut) begin
        cutoff = 1;
      end else if (!(t >= slo && t <= shi)) begin
        px = idx % pw;
        py = idx / pw;
        in = px >= pad && px < pad + 4 && py >= pad && py < pad + 3;
        a = (py - pad) * 4 + (px - pad);
        ab = a[7:0];
        d = in ? {3{ab}} : 24'h0;
        push_ev(b, 1, t + 1, d);
        idx++;
        t++;
      end else begin
        t++;
      end
    end
    if (!cutoff) push_ev(b, 2, t + 1, 24'h0);
  endtask

  task automatic chk_ev(input string nm, input ev_t e, input int k,
                        input int c, input logic [23:0] d,
                        input logic bz);
    logic wb;
    wb = (k != 2);
    total++;
    if (e.kind != k || e.cyc != c || e.d !== d || bz !== wb) begin
      bad++;
      $display("FAIL %s: got kind=%0d cyc=%0d D=%h busy=%b, want kind=%0d cyc=%0d D=%h busy=%b",
               nm, k, c, d, bz, e.kind, e.cyc, e.d, wb);
    end
  endtask

  always @(negedge clk) begin
    int k;
    ev_t e;
    if (a_if.mem_en) begin
      total++;
      if (a_if.mem_addr !== 10'(exp_a)) begin
        bad++;
        $display("FAIL a.addr: got %0d want %0d", a_if.mem_addr, exp_a);
      end
      exp_a++;
    end
    k = a_if.flush ? 0 : a_if.valid ? 1 : done_a ? 2 : -1;
    if (k == 0) exp_a = 0;
    if (k >= 0) begin
      if (qa.size() == 0) begin
        total++;
        bad++;
        $display("FAIL a.unexpected: got kind=%0d cyc=%0d want none",
                 k, cyc - base_a);
      end else begin
        e = qa.pop_front();
        chk_ev("a.event", e, k, cyc - base_a, a_if.D, busy_a);
      end
    end
  end

  always @(negedge clk) begin
    int k;
    ev_t e;
    if (b_if.mem_en) begin
      total++;
      if (b_if.mem_addr !== 10'(exp_b)) begin
        bad++;
        $display("FAIL b.addr: got %0d want %0d", b_if.mem_addr, exp_b);
      end
      exp_b++;
    end
    k = b_if.flush ? 0 : b_if.valid ? 1 : done_b ? 2 : -1;
    if (k == 0) exp_b = 0;
    if (k >= 0) begin
      if (qb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL b.unexpected: got kind=%0d cyc=%0d want none",
                 k, cyc - base_b);
      end else begin
        e = qb.pop_front();
        chk_ev("b.event", e, k, cyc - base_b, b_if.D, busy_b);
      end
    end
  end

  task automatic chk_zero_a(input string nm);
    total++;
    if ({a_if.mem_en, a_if.mem_addr, a_if.flush, a_if.valid,
         a_if.D, busy_a, done_a} !== '0) begin
      bad++;
      $display("FAIL %s: got en=%b addr=%0d flush=%b valid=%b D=%h busy=%b done=%b want all 0",
               nm, a_if.mem_en, a_if.mem_addr, a_if.flush, a_if.valid,
               a_if.D, busy_a, done_a);
    end
  endtask

  task automatic chk_drain(input bit b, input string nm);
    int n;
    n = b ? qb.size() : qa.size();
    total++;
    if (n != 0) begin
      bad++;
      $display("FAIL %s: got %0d pending events want 0", nm, n);
      if (b) qb.delete();
      else   qa.delete();
    end
  endtask

  task automatic run_a(input string nm, input int n, input int st_len,
                       input int slo, input int shi, input int rst_cyc);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) base_a = cyc;
      start_a = (k < st_len);
      stall_a = (k >= slo && k <= shi);
      if (k == rst_cyc) rstn = 1'b0;
      if (k == rst_cyc + 1) begin
        chk_zero_a("a.reset_mid");
        rstn = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    start_a = 1'b0;
    stall_a = 1'b0;
    chk_drain(1'b0, nm);
  endtask

  task automatic run_b(input string nm, input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) base_b = cyc;
      start_b = (k == 0);
    end
    @(posedge clk);
    #1;
    start_b = 1'b0;
    chk_drain(1'b1, nm);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_zero_a("a.reset");
    total++;
    if ({b_if.mem_en, b_if.flush, b_if.valid, b_if.D,
         busy_b, done_b} !== '0) begin
      bad++;
      $display("FAIL b.reset: got nonzero outputs want all 0");
    end
    rstn = 1'b1;
    repeat (2) @(posedge clk);

    push_frame(1'b0, 0, -10, -10, 1000);
    run_a("a.plain", 36, 1, -10, -10, -10);

    push_frame(1'b1, 0, -10, -10, 1000);
    run_b("b.pad0", 18);

    push_frame(1'b0, 0, 5, 7, 1000);
    run_a("a.stall", 40, 1, 5, 7, -10);

    push_frame(1'b0, 0, -10, -10, 10);
    run_a("a.abort", 20, 1, -10, -10, 10);
    push_frame(1'b0, 0, -10, -10, 1000);
    run_a("a.restart", 36, 1, -10, -10, -10);

    push_frame(1'b0, 0, -10, -10, 1000);
    push_frame(1'b0, 34, -10, -10, 1000);
    run_a("a.held", 72, 40, -10, -10, -10);

    push_frame(1'b0, 0, 0, 3, 1000);
    run_a("a.idle_stall", 40, 1, 0, 3, -10);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fmap_streamer.md
# fmap_streamer

Raster-scan source that reads a stored input feature map from a single-port synchronous RAM and streams it, zero-padded, into the convolution line buffer as one packed multi-channel pixel per cycle. It is the producer side of the line buffer's `valid`/`flush`/`D` input protocol. It sits between the activation RAM and the line buffer. It issues a `flush` before each frame, emits every padded pixel exactly once in row-major order, and reports completion to the layer controller.

## Interface
- `BITWIDTH`, 8, bits per channel sample
- `INPUT_FMAPS`, 3, channels packed per pixel; channel 0 in LSBs
- `IMG_W`, 32, unpadded image width in pixels
- `IMG_H`, 32, unpadded image height in pixels
- `PAD`, 1, zero border width on every side, 0..3
- `AW`, 10, RAM address width; requires `IMG_W*IMG_H <= 2**AW`

Ports:
- `clk`, in, 1, clock
- `rstn`, in, 1, reset: synchronous, active-low; clock `clk`
- `start`, in, 1, frame request, sampled only in IDLE
- `stall`, in, 1, downstream hold; blocks new RAM issues
- `mem_en`, out, 1, RAM read enable
- `mem_addr`, out, AW, RAM read address
- `mem_rdata`, in, BITWIDTH*INPUT_FMAPS, RAM data, valid 1 cycle after `mem_en`
- `flush`, out, 1, line-buffer clear pulse
- `valid`, out, 1, `D` carries a pixel this cycle
- `D`, out, BITWIDTH*INPUT_FMAPS, pixel to line buffer
- `busy`, out, 1, frame in progress
- `done`, out, 1, one-cycle frame-complete pulse

## Operation
- Padded frame: PW = IMG_W+2·PAD, PH = IMG_H+2·PAD, P = PW·PH pixels. Counters px in 0..PW-1 and py in 0..PH-1 scan row-major, with px advancing first.
- A position is interior when PAD ≤ px < PAD+IMG_W and PAD ≤ py < PAD+IMG_H.
  - Interior position: `mem_en`=1 and `mem_addr` = (py-PAD)·IMG_W + (px-PAD), computed with an incrementing address register, not a multiplier.
  - Border position: `mem_en`=0 and `D` is all zeros.
- One-stage pipeline. An issue at cycle t (interior or border) registers an is-pad flag. At t+1, `valid`=1 and `D` = is-pad ? 0 : `mem_rdata`.
- FSM states:
  - IDLE: `start` is sampled; if high, go to FLUSH.
  - FLUSH: one cycle with `flush`=1; counters clear to (0,0); go to STREAM.
  - STREAM: on each cycle with `stall`=0, issue the current position and advance the counters. When the issue at (PW-1, PH-1) is made, go to DRAIN. A cycle with `stall`=1 issues nothing, and counters and address hold.
  - DRAIN: one cycle presenting the last `valid`; go to DONE.
  - DONE: `done`=1 for one cycle; go to IDLE.
- `busy`=1 in FLUSH, STREAM and DRAIN, and 0 in IDLE and DONE.
- `start` is ignored outside IDLE. `start` held high re-triggers a new frame on the cycle after DONE (when the FSM is back in IDLE).
- `stall` is honoured only in STREAM; it is ignored in FLUSH, DRAIN and DONE.
- With PAD=0 every position is interior. `mem_addr` runs 0..IMG_W·IMG_H-1 contiguously.

## Timing
- Reset is synchronous. With `rstn`=0 at an edge, the FSM goes to IDLE, counters clear and the pipeline flag clears. All outputs are 0 after that edge: `mem_en`, `mem_addr`, `flush`, `valid`, `D`, `busy`, `done`.
- Reset mid-frame aborts with no `done`. The next frame requires a fresh `start`.
- Start latency with no stall (`start` high at edge 0):
  - `flush`=1 in cycle 1.
  - First issue in cycle 2.
  - First `valid` in cycle 3.
  - Last `valid` in cycle P+2.
  - `done` in cycle P+3.
- Stall semantics: `stall` high in cycle t suppresses the issue in t, giving `valid`=0 in t+1. The pixel issued in t-1 is still delivered in t, so the receiver must absorb one in-flight pixel after raising `stall`.
- Each stalled cycle adds exactly one cycle to the `done` latency.
- `valid` is never high in the same cycle as `flush`. No pixel is duplicated or dropped across a stall.

## Test plan
- Small frame (IMG_W=4, IMG_H=3, PAD=1; RAM word a = {3{a[7:0]}}), `start` pulse, no stall → `flush` in cycle 1, then 30 `valid` beats in cycles 3..32, then `done` in cycle 33.
  - First 7 beats: 0x000000.
  - Beat 8: 0x000000 (address 0).
  - Beat 9: 0x010101.
  - Beats 12..13: 0x000000.
  - Final 7 beats: 0x000000.
  - Interior addresses run 0..11 in order.
- PAD=0, same RAM → 12 beats with D = {3{k}} for k=0..11, and `done` in cycle 15.
- Same frame as scenario 1 with `stall` high during cycles 5..7 → `valid` low in cycles 6..8, the beat sequence is identical to scenario 1, and `done` moves to cycle 36.
- `rstn` low in cycle 10 → all outputs 0 from cycle 11 and no `done`. A subsequent `start` gives `flush` one cycle later and restarts at address 0.
- `start` held high for 40 cycles → `start` is ignored while busy. A second `flush` occurs 2 cycles after the first `done`, since the FSM passes through IDLE first.
- `start` and `stall` both high in IDLE → normal `flush` in cycle 1. Issues begin the first STREAM cycle with `stall` low.
